// File: rtl/exec_writeback_unit.sv
// exec_writeback_unit: execute/write-back sequencer sitting behind a single-port-per-cycle
// register file. Each accepted instruction takes READ -> EXEC -> WRITE (or back to IDLE for
// NOP/illegal), giving one instruction every four cycles.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   instr_valid/ready       decoder handshake; instr_op/rs1/rs2/rd sampled on acceptance
//   rf_selA/selB/selWrite   register file selects
//   rf_writeIn, rf_isReading register file write data and read/write mode (0 only in WRITE)
//   rf_outA/outB            registered read data from the register file
//   result_valid            high for the WRITE cycle
//   flag_zero/flag_carry    flags of the last written result
//   illegal_op              one-cycle pulse after EXEC of opcode 111
//   retire_count            (only with RETIRE_COUNT_EN) count of committed writes
//
// Optional feature macro: RETIRE_COUNT_EN
module exec_writeback_unit #(
  parameter int unsigned REG_ADDRESS_SIZE = 2,
  parameter int unsigned MEM_WORD_SIZE    = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        instr_valid,
  output logic                        instr_ready,
  input  logic [2:0]                  instr_op,
  input  logic [REG_ADDRESS_SIZE-1:0] instr_rs1,
  input  logic [REG_ADDRESS_SIZE-1:0] instr_rs2,
  input  logic [REG_ADDRESS_SIZE-1:0] instr_rd,
  output logic [REG_ADDRESS_SIZE-1:0] rf_selA,
  output logic [REG_ADDRESS_SIZE-1:0] rf_selB,
  output logic [REG_ADDRESS_SIZE-1:0] rf_selWrite,
  output logic [MEM_WORD_SIZE-1:0]    rf_writeIn,
  output logic                        rf_isReading,
  input  logic [MEM_WORD_SIZE-1:0]    rf_outA,
  input  logic [MEM_WORD_SIZE-1:0]    rf_outB,
  output logic                        result_valid,
  output logic                        flag_zero,
  output logic                        flag_carry,
  output logic                        illegal_op
`ifdef RETIRE_COUNT_EN
  ,
  output logic [31:0]                 retire_count
`endif
);

  localparam logic [2:0] OpAdd   = 3'b000;
  localparam logic [2:0] OpSub   = 3'b001;
  localparam logic [2:0] OpAnd   = 3'b010;
  localparam logic [2:0] OpOr    = 3'b011;
  localparam logic [2:0] OpXor   = 3'b100;
  localparam logic [2:0] OpPassa = 3'b101;
  localparam logic [2:0] OpNop   = 3'b110;
  localparam logic [2:0] OpIll   = 3'b111;

  localparam logic [MEM_WORD_SIZE:0] WideOne = {{MEM_WORD_SIZE{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWrite} state_e;

  state_e                      state_q, state_d;
  logic [2:0]                  op_q, op_d;
  logic [REG_ADDRESS_SIZE-1:0] rd_q, rd_d;
  logic [REG_ADDRESS_SIZE-1:0] sel_a_q, sel_a_d;
  logic [REG_ADDRESS_SIZE-1:0] sel_b_q, sel_b_d;
  logic [REG_ADDRESS_SIZE-1:0] sel_write_q, sel_write_d;
  logic [MEM_WORD_SIZE-1:0]    write_in_q, write_in_d;
  logic                        is_reading_q, is_reading_d;
  logic                        result_valid_q, result_valid_d;
  logic                        flag_zero_q, flag_zero_d;
  logic                        flag_carry_q, flag_carry_d;
  logic                        carry_pend_q, carry_pend_d;
  logic                        illegal_q, illegal_d;
`ifdef RETIRE_COUNT_EN
  logic [31:0]                 retire_q, retire_d;
`endif

  logic [MEM_WORD_SIZE:0]   sum_add, sum_sub;
  logic [MEM_WORD_SIZE-1:0] alu_res;
  logic                     alu_carry;

  // The file's outputs are sampled straight into the result register at the EXEC closing
  // edge, so when rd aliases rs1/rs2 the pre-write operand values are used.
  always_comb begin
    sum_add   = {1'b0, rf_outA} + {1'b0, rf_outB};
    sum_sub   = {1'b0, rf_outA} + {1'b0, ~rf_outB} + WideOne;
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      OpAdd:   begin alu_res = sum_add[MEM_WORD_SIZE-1:0]; alu_carry = sum_add[MEM_WORD_SIZE]; end
      // No carry-out of A + ~B + 1 means A < B, i.e. a borrow.
      OpSub:   begin alu_res = sum_sub[MEM_WORD_SIZE-1:0]; alu_carry = ~sum_sub[MEM_WORD_SIZE]; end
      OpAnd:   alu_res = rf_outA & rf_outB;
      OpOr:    alu_res = rf_outA | rf_outB;
      OpXor:   alu_res = rf_outA ^ rf_outB;
      OpPassa: alu_res = rf_outA;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    rd_d           = rd_q;
    sel_a_d        = sel_a_q;
    sel_b_d        = sel_b_q;
    sel_write_d    = sel_write_q;
    write_in_d     = write_in_q;
    is_reading_d   = 1'b1;
    result_valid_d = 1'b0;
    flag_zero_d    = flag_zero_q;
    flag_carry_d   = flag_carry_q;
    carry_pend_d   = carry_pend_q;
    illegal_d      = 1'b0;
`ifdef RETIRE_COUNT_EN
    retire_d       = retire_q;
`endif
    case (state_q)
      StIdle: begin
        if (instr_valid) begin
          op_d    = instr_op;
          rd_d    = instr_rd;
          sel_a_d = instr_rs1;
          sel_b_d = instr_rs2;
          state_d = StRead;
        end
      end
      StRead: state_d = StExec;
      StExec: begin
        if (op_q == OpNop) begin
          state_d = StIdle;
        end else if (op_q == OpIll) begin
          illegal_d = 1'b1;
          state_d   = StIdle;
        end else begin
          write_in_d     = alu_res;
          sel_write_d    = rd_q;
          carry_pend_d   = alu_carry;
          is_reading_d   = 1'b0;
          result_valid_d = 1'b1;
          state_d        = StWrite;
        end
      end
      StWrite: begin
        flag_zero_d  = (write_in_q == '0);
        flag_carry_d = carry_pend_q;
`ifdef RETIRE_COUNT_EN
        retire_d     = retire_q + 32'd1;
`endif
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      op_q           <= '0;
      rd_q           <= '0;
      sel_a_q        <= '0;
      sel_b_q        <= '0;
      sel_write_q    <= '0;
      write_in_q     <= '0;
      is_reading_q   <= 1'b1;
      result_valid_q <= 1'b0;
      flag_zero_q    <= 1'b0;
      flag_carry_q   <= 1'b0;
      carry_pend_q   <= 1'b0;
      illegal_q      <= 1'b0;
`ifdef RETIRE_COUNT_EN
      retire_q       <= '0;
`endif
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      rd_q           <= rd_d;
      sel_a_q        <= sel_a_d;
      sel_b_q        <= sel_b_d;
      sel_write_q    <= sel_write_d;
      write_in_q     <= write_in_d;
      is_reading_q   <= is_reading_d;
      result_valid_q <= result_valid_d;
      flag_zero_q    <= flag_zero_d;
      flag_carry_q   <= flag_carry_d;
      carry_pend_q   <= carry_pend_d;
      illegal_q      <= illegal_d;
`ifdef RETIRE_COUNT_EN
      retire_q       <= retire_d;
`endif
    end
  end

  assign instr_ready  = (state_q == StIdle);
  assign rf_selA      = sel_a_q;
  assign rf_selB      = sel_b_q;
  assign rf_selWrite  = sel_write_q;
  assign rf_writeIn   = write_in_q;
  assign rf_isReading = is_reading_q;
  assign result_valid = result_valid_q;
  assign flag_zero    = flag_zero_q;
  assign flag_carry   = flag_carry_q;
  assign illegal_op   = illegal_q;
`ifdef RETIRE_COUNT_EN
  assign retire_count = retire_q;
`endif

endmodule

// File: tb/tb_exec_writeback_unit.sv
// Bench for exec_writeback_unit: behavioural register file, directed vector table,
// hand-written corner sequences and a randomized run against a reference model.
module tb_exec_writeback_unit;

  localparam int RW = 2;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [2:0]    instr_op = '0;
  logic [RW-1:0] instr_rs1 = '0, instr_rs2 = '0, instr_rd = '0;
  logic [RW-1:0] rf_selA, rf_selB, rf_selWrite;
  logic [DW-1:0] rf_writeIn;
  logic          rf_isReading;
  logic [DW-1:0] rf_outA = '0, rf_outB = '0;
  logic          result_valid, flag_zero, flag_carry, illegal_op;
`ifdef RETIRE_COUNT_EN
  logic [31:0]   retire_count;
`endif

  exec_writeback_unit #(.REG_ADDRESS_SIZE(RW), .MEM_WORD_SIZE(DW)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_rd(instr_rd),
    .rf_selA(rf_selA), .rf_selB(rf_selB), .rf_selWrite(rf_selWrite),
    .rf_writeIn(rf_writeIn), .rf_isReading(rf_isReading),
    .rf_outA(rf_outA), .rf_outB(rf_outB),
    .result_valid(result_valid), .flag_zero(flag_zero), .flag_carry(flag_carry),
    .illegal_op(illegal_op)
`ifdef RETIRE_COUNT_EN
    , .retire_count(retire_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural register file: one read or one write per edge, plus a bench preload path.
  logic [DW-1:0] rf_mem [4];
  logic          pre_en = 1'b0;
  logic [RW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_en) rf_mem[pre_addr] <= pre_data;
    else if (!rf_isReading) rf_mem[rf_selWrite] <= rf_writeIn;
    if (rf_isReading) begin
      rf_outA <= rf_mem[rf_selA];
      rf_outB <= rf_mem[rf_selB];
    end
  end

  // Cycle monitor, sampled on the falling edge.
  int cyc = 0;
  int wr_cnt = 0, rv_cnt = 0, ill_cnt = 0, rdy_low = 0, rv_bad = 0, last_wr_cyc = -1;
  logic [RW-1:0] last_wr_sel = '0;
  logic [DW-1:0] last_wr_data = '0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!rf_isReading) begin
      wr_cnt++;
      last_wr_cyc  = cyc;
      last_wr_sel  = rf_selWrite;
      last_wr_data = rf_writeIn;
    end
    if (result_valid) rv_cnt++;
    if (result_valid !== !rf_isReading) rv_bad++;
    if (illegal_op) ill_cnt++;
    if (!instr_ready) rdy_low++;
  end

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  logic [DW-1:0] ref_regs [4];
  logic          ref_zero = 1'b0, ref_carry = 1'b0;
  int            ref_retire = 0;
  logic [DW-1:0] last_res;
  logic          last_carry;

  task automatic model_exec(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            output logic [DW-1:0] res, output logic carry, output logic wr,
                            output logic ill);
    res = '0; carry = 1'b0; wr = 1'b1; ill = 1'b0;
    case (op)
      3'd0: begin res = a + b; carry = (res < a); end
      3'd1: begin res = a - b; carry = (a < b); end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: res = a;
      3'd6: wr = 1'b0;
      default: begin wr = 1'b0; ill = 1'b1; end
    endcase
  endtask

  task automatic preload(input logic [RW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = addr; pre_data = data;
    @(negedge clk);
    pre_en = 1'b0;
    ref_regs[addr] = data;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ref_zero = 1'b0; ref_carry = 1'b0; ref_retire = 0;
  endtask

  // Issue one instruction, run it to completion and check it against the model.
  task automatic do_instr(input logic [2:0] op, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                          input logic [RW-1:0] rd, output int t0);
    logic [DW-1:0] a, b, res;
    logic c, w, il;
    int wr0, ill0, rv0, waited;
    a = ref_regs[rs1]; b = ref_regs[rs2];
    model_exec(op, a, b, res, c, w, il);
    wr0 = wr_cnt; ill0 = ill_cnt; rv0 = rv_cnt;
    @(negedge clk);
    waited = 0;
    while (!instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!instr_ready) begin
      total++; bad++;
      $display("FAIL ready_timeout: got ready=0 want ready=1 within 20 cycles");
    end
    instr_valid = 1'b1; instr_op = op; instr_rs1 = rs1; instr_rs2 = rs2; instr_rd = rd;
    @(posedge clk);
    #1;
    t0 = cyc;
    // Junk held valid while busy must be ignored.
    instr_op = 3'($urandom); instr_rs1 = 2'($urandom); instr_rs2 = 2'($urandom);
    instr_rd = 2'($urandom);
    @(posedge clk);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    if (w) begin
      ref_regs[rd] = res; ref_zero = (res == '0); ref_carry = c; ref_retire++;
    end
    last_res = res; last_carry = c;
    check($sformatf("writes op%0d", op), 64'(wr_cnt - wr0), 64'(w));
    check($sformatf("result_valid op%0d", op), 64'(rv_cnt - rv0), 64'(w));
    check($sformatf("illegal op%0d", op), 64'(ill_cnt - ill0), 64'(il));
    check($sformatf("rf[%0d] op%0d", rd, op), rf_mem[rd], ref_regs[rd]);
    check($sformatf("flag_zero op%0d", op), 64'(flag_zero), 64'(ref_zero));
    check($sformatf("flag_carry op%0d", op), 64'(flag_carry), 64'(ref_carry));
    if (w) begin
      check($sformatf("writeIn op%0d", op), last_wr_data, res);
      check($sformatf("selWrite op%0d", op), 64'(last_wr_sel), 64'(rd));
    end
`ifdef RETIRE_COUNT_EN
    check("retire_count", 64'(retire_count), 64'(ref_retire));
`endif
  endtask

  typedef struct {
    logic [2:0]    op;
    logic [RW-1:0] rs1, rs2, rd;
    logic [DW-1:0] a, b, res;
    logic          carry;
  } vec_t;
  vec_t vecs [10];

  initial begin
    int t0, w0, r0, rl0, i0;
    logic [DW-1:0] saved;

    vecs[0] = '{3'd0, 2'd1, 2'd2, 2'd3, 64'd5, 64'd7, 64'd12, 1'b0};
    vecs[1] = '{3'd0, 2'd1, 2'd2, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1};
    vecs[2] = '{3'd1, 2'd2, 2'd1, 2'd3, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1};
    vecs[3] = '{3'd2, 2'd0, 2'd1, 2'd2, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0};
    vecs[4] = '{3'd3, 2'd0, 2'd1, 2'd2, 64'hF0F0, 64'h0F0F, 64'hFFFF, 1'b0};
    vecs[5] = '{3'd4, 2'd3, 2'd2, 2'd0, 64'hFFFF, 64'hFFFF, 64'd0, 1'b0};
    vecs[6] = '{3'd5, 2'd1, 2'd2, 2'd3, 64'hDEAD_BEEF, 64'h123, 64'hDEAD_BEEF, 1'b0};
    vecs[7] = '{3'd1, 2'd0, 2'd3, 2'd1, 64'd10, 64'd10, 64'd0, 1'b0};
    vecs[8] = '{3'd0, 2'd1, 2'd2, 2'd1, 64'd3, 64'd4, 64'd7, 1'b0};
    vecs[9] = '{3'd1, 2'd2, 2'd3, 2'd0, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};

    for (int i = 0; i < 4; i++) begin
      rf_mem[i] = '0;
      ref_regs[i] = '0;
    end

    // Reset state.
    #12;
    reset = 1'b0;
    #1;
    check("reset isReading", 64'(rf_isReading), 64'd1);
    check("reset ready", 64'(instr_ready), 64'd1);
    check("reset sels", 64'({rf_selA, rf_selB, rf_selWrite}), 64'd0);
    check("reset writeIn", rf_writeIn, 64'd0);
    check("reset pulses", 64'({result_valid, illegal_op}), 64'd0);
    check("reset flags", 64'({flag_zero, flag_carry}), 64'd0);
`ifdef RETIRE_COUNT_EN
    check("reset retire", 64'(retire_count), 64'd0);
`endif

    // Idle for 10 cycles.
    w0 = wr_cnt; r0 = rv_cnt; rl0 = rdy_low;
    repeat (10) @(posedge clk);
    #1;
    check("idle writes", 64'(wr_cnt - w0), 64'd0);
    check("idle result_valid", 64'(rv_cnt - r0), 64'd0);
    check("idle ready_low", 64'(rdy_low - rl0), 64'd0);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      preload(vecs[i].rs1, vecs[i].a);
      preload(vecs[i].rs2, vecs[i].b);
      w0 = wr_cnt; rl0 = rdy_low;
      do_instr(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, t0);
      check($sformatf("vec%0d result", i), last_wr_data, vecs[i].res);
      check($sformatf("vec%0d carry", i), 64'(flag_carry), 64'(vecs[i].carry));
      check($sformatf("vec%0d zero", i), 64'(flag_zero), 64'(vecs[i].res == '0));
      if (i == 0) begin
        check("add write cycle", 64'(last_wr_cyc), 64'(t0 + 2));
        check("add ready_low cycles", 64'(rdy_low - rl0), 64'd3);
        check("add ready back", 64'(instr_ready), 64'd1);
      end
    end

    // NOP then illegal: no writes, one illegal pulse, flags preserved.
    preload(2'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    preload(2'd2, 64'd1);
    do_instr(3'd0, 2'd1, 2'd2, 2'd0, t0);  // leaves zero=1, carry=1
    w0 = wr_cnt; i0 = ill_cnt;
    do_instr(3'd6, 2'd1, 2'd2, 2'd3, t0);
    check("nop no illegal", 64'(ill_cnt - i0), 64'd0);
    do_instr(3'd7, 2'd1, 2'd2, 2'd3, t0);
    check("nop+ill writes", 64'(wr_cnt - w0), 64'd0);
    check("nop+ill illegal pulses", 64'(ill_cnt - i0), 64'd1);
    check("nop+ill flags kept", 64'({flag_zero, flag_carry}), 64'b11);

    // Reset during EXEC of an ADD: abort, no write, destination untouched.
    preload(2'd1, 64'd100);
    preload(2'd2, 64'd200);
    preload(2'd3, 64'h55);
    saved = ref_regs[3];
    w0 = wr_cnt;
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 3'd0; instr_rs1 = 2'd1; instr_rs2 = 2'd2; instr_rd = 2'd3;
    @(posedge clk);  // T0
    #1;
    instr_valid = 1'b0;
    @(posedge clk);  // T1: now in EXEC
    #2;
    reset = 1'b1;
    #1;
    check("abort isReading", 64'(rf_isReading), 64'd1);
    check("abort ready", 64'(instr_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    ref_zero = 1'b0; ref_carry = 1'b0; ref_retire = 0;
    repeat (4) @(posedge clk);
    #1;
    check("abort writes", 64'(wr_cnt - w0), 64'd0);
    check("abort rf[3]", rf_mem[3], saved);
    do_instr(3'd5, 2'd3, 2'd3, 2'd0, t0);  // read rd back through the unit
    check("abort readback", last_wr_data, saved);

    // Randomized run against the model.
    for (int i = 0; i < 4; i++) preload(2'(i), {$urandom, $urandom});
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 2))
          0: preload(2'($urandom), 64'd0);
          1: preload(2'($urandom), 64'hFFFF_FFFF_FFFF_FFFF);
          default: preload(2'($urandom), 64'($urandom_range(0, 3)));
        endcase
      end
      do_instr(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), t0);
    end

`ifdef RETIRE_COUNT_EN
    do_reset();
    preload(2'd1, 64'd1);
    preload(2'd2, 64'd2);
    do_instr(3'd0, 2'd1, 2'd2, 2'd3, t0);
    do_instr(3'd0, 2'd1, 2'd2, 2'd3, t0);
    do_instr(3'd0, 2'd1, 2'd2, 2'd3, t0);
    do_instr(3'd6, 2'd1, 2'd2, 2'd3, t0);
    check("retire after 3 add + nop", 64'(retire_count), 64'd3);
`endif

    check("result_valid tracks write", 64'(rv_bad), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exec_writeback_unit.md
Name: exec_writeback_unit

Overview:
Execute/write-back controller that sits directly downstream of the register file. It consumes the file's registered read outputs (outA/outB), computes a 64-bit ALU result, and feeds it back into the file's write port. The register file performs either one read or one write per cycle (isReading selects which), so this block also sequences each instruction into a read cycle, an execute cycle and a write cycle. Instructions arrive from the decoder over a valid/ready handshake.

Parameters:
REG_ADDRESS_SIZE, 2, register select width; must match the register file.
MEM_WORD_SIZE, 64, datapath width; must match the register file.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  asynchronous, active-high reset.
instr_valid  input  1  decoder holds a valid instruction.
instr_ready  output  1  unit can accept an instruction this cycle.
instr_op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 PASSA, 110 NOP, 111 illegal.
instr_rs1  input  REG_ADDRESS_SIZE  source A select.
instr_rs2  input  REG_ADDRESS_SIZE  source B select.
instr_rd  input  REG_ADDRESS_SIZE  destination select.
rf_selA  output  REG_ADDRESS_SIZE  register file selA.
rf_selB  output  REG_ADDRESS_SIZE  register file selB.
rf_selWrite  output  REG_ADDRESS_SIZE  register file selWrite.
rf_writeIn  output  MEM_WORD_SIZE  register file writeIn.
rf_isReading  output  1  register file isReading; 0 only in WRITE.
rf_outA  input  MEM_WORD_SIZE  register file outA.
rf_outB  input  MEM_WORD_SIZE  register file outB.
result_valid  output  1  one-cycle pulse while a write is issued.
flag_zero  output  1  last written result == 0.
flag_carry  output  1  ADD carry-out, or SUB borrow (A < B unsigned).
illegal_op  output  1  one-cycle pulse on opcode 111.

Behaviour:
- The register file writes on every edge where isReading=0. rf_isReading is therefore 1 in every state except WRITE, including during reset and IDLE.
- Reset, applied asynchronously: state=IDLE; rf_isReading=1; all sel outputs=0; rf_writeIn=0; result_valid=0; flag_zero=0; flag_carry=0; illegal_op=0.
- FSM states: IDLE, READ, EXEC, WRITE.
- IDLE:
  - instr_ready=1.
  - On instr_valid, latch op/rs1/rs2/rd, drive rf_selA=rs1 and rf_selB=rs2, and go to READ.
- READ:
  - instr_ready=0; rf_selA/rf_selB held; rf_isReading=1.
  - On the closing edge the file registers outA/outB. Go to EXEC.
- EXEC:
  - Capture rf_outA/rf_outB into internal operand registers.
  - Compute a 65-bit intermediate; the result is the low MEM_WORD_SIZE bits.
  - ADD: carry = bit 64. SUB: A + ~B + 1; carry = 1 when A < B unsigned. Logic ops and PASSA: carry = 0.
  - Register the result into rf_writeIn and rf_selWrite=rd.
  - Ops 000–101 go to WRITE.
  - NOP: go to IDLE; no write; flags unchanged.
  - Op 111: pulse illegal_op in the cycle after EXEC, go to IDLE; no write; flags unchanged.
- WRITE:
  - rf_isReading=0; result_valid=1.
  - On the closing edge the file stores the result, flag_zero and flag_carry update, and the FSM goes to IDLE.
- Latency:
  - Handshake edge T0. Write commits at edge T3.
  - Next instruction can be accepted at edge T4 (IDLE during T3–T4). Throughput is 1 instruction per 4 cycles.
- The handshake completes only on an edge with instr_valid && instr_ready. Inputs are ignored while instr_ready=0.
- rd may equal rs1 or rs2. Operands are captured in EXEC, before the write, so the old values are used.
- Reset asserted mid-instruction: the FSM aborts immediately and no write is issued. Because isReading is forced high, the register file contents are not corrupted by this block.
- Arithmetic wraps modulo 2^MEM_WORD_SIZE.

Optional Feature:
RETIRE_COUNT_EN:
- Defined: adds output port retire_count (32 bits). Reset value 0. Increments on each WRITE closing edge; NOP and illegal ops are not counted. Wraps 0xFFFFFFFF→0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then hold instr_valid=0 for 10 cycles → rf_isReading=1 every cycle, result_valid never asserted, instr_ready=1.
- Register file preloaded r1=5, r2=7; ADD rd=3,rs1=1,rs2=2 at T0 → rf_isReading=0 only in T2–T3 with rf_selWrite=3 and rf_writeIn=12; result_valid pulses once; flag_zero=0, flag_carry=0; instr_ready returns at T3.
- r1=0xFFFF_FFFF_FFFF_FFFF, r2=1: ADD rd=0 → writeIn=0, flag_zero=1, flag_carry=1. Then SUB r2-r1 → writeIn=2, flag_carry=1 (borrow).
- Op 110, then op 111 → no cycle with rf_isReading=0; illegal_op pulses once for 111 only; flags keep their prior values.
- Assert reset during the EXEC cycle of an ADD → next cycle is IDLE, no write occurs, and a register readback shows the destination unchanged.
- With RETIRE_COUNT_EN: 3 ADDs + 1 NOP → retire_count=3.
